// File: rtl/gp_engine_pkg.sv
// Shared GP engine parameters and helpers.
// Command buffer geometry and the command high-word rotate.
package gp_engine_pkg;

  localparam int CMD_WIDTH        = 64;
  localparam int DATA_WIDTH       = 32;
  localparam int BUFFER_WIDTH     = 32;
  localparam int BUFFER_DEPTH     = 256;
  localparam int TRANS_ADDR_WIDTH = 8;

  typedef logic [BUFFER_WIDTH-1:0] buf_word_t;

  function automatic buf_word_t rotr2(
    input buf_word_t w
  );
    return {w[1:0], w[BUFFER_WIDTH-1:2]};
  endfunction

endpackage

// File: rtl/cmd_buffer_if.sv
// Bus-side and engine-side ports of the command buffer.
// master = requester, slave = cmd_buffer.
interface cmd_slv_if
  import gp_engine_pkg::*;
#(
  parameter int AW = TRANS_ADDR_WIDTH,
  parameter int DW = DATA_WIDTH
) ();

  logic          cmd_en;
  logic [AW-1:0] trans_addr;
  logic          slv_o_valid;
  logic [DW-1:0] slv_o_wr_data;
  logic          slv_o_rd0_wr1;
  logic          slv_i_ready;
  logic [DW-1:0] slv_i_rd_data;
  logic          slv_i_rd_valid;

  modport master (
    output cmd_en,
    output trans_addr,
    output slv_o_valid,
    output slv_o_wr_data,
    output slv_o_rd0_wr1,
    input  slv_i_ready,
    input  slv_i_rd_data,
    input  slv_i_rd_valid
  );

  modport slave (
    input  cmd_en,
    input  trans_addr,
    input  slv_o_valid,
    input  slv_o_wr_data,
    input  slv_o_rd0_wr1,
    output slv_i_ready,
    output slv_i_rd_data,
    output slv_i_rd_valid
  );

endinterface

interface cmd_rd_if
  import gp_engine_pkg::*;
#(
  parameter int AW = TRANS_ADDR_WIDTH,
  parameter int CW = CMD_WIDTH
) ();

  logic          cmd_rd_en;
  logic [AW-1:0] cmd_addr;
  logic          cmd_rd_valid;
  logic [CW-1:0] cmd_out;

  modport master (
    output cmd_rd_en,
    output cmd_addr,
    input  cmd_rd_valid,
    input  cmd_out
  );

  modport slave (
    input  cmd_rd_en,
    input  cmd_addr,
    output cmd_rd_valid,
    output cmd_out
  );

endinterface

// File: rtl/cmd_buffer.sv
// GP engine command memory: word-wide bus port plus
// a two-word command read port for the engine FSM.
module cmd_buffer
  import gp_engine_pkg::*;
#(
  parameter int CMD_WIDTH        = gp_engine_pkg::CMD_WIDTH,
  parameter int DATA_WIDTH       = gp_engine_pkg::DATA_WIDTH,
  parameter int BUFFER_WIDTH     = gp_engine_pkg::BUFFER_WIDTH,
  parameter int BUFFER_DEPTH     = gp_engine_pkg::BUFFER_DEPTH,
  parameter int TRANS_ADDR_WIDTH = gp_engine_pkg::TRANS_ADDR_WIDTH
) (
  input logic      clk,
  input logic      rst_n,
  cmd_slv_if.slave slv,
  cmd_rd_if.slave  eng
);

  localparam int AW = TRANS_ADDR_WIDTH;

  // Flops rather than RAM: every word must clear on async reset.
  logic [BUFFER_WIDTH-1:0] cmd_mem [0:BUFFER_DEPTH-1];

  logic                    slv_wr;
  logic                    slv_rd;
  logic                    eng_go;
  logic [AW-1:0]           addr_hi;

  logic                    slv_rd_valid_d, slv_rd_valid_q;
  logic [DATA_WIDTH-1:0]   slv_rd_data_d,  slv_rd_data_q;
  logic                    cmd_rd_valid_d, cmd_rd_valid_q;
  logic [CMD_WIDTH-1:0]    cmd_out_d,      cmd_out_q;

  always_comb begin
    slv_wr = slv.cmd_en & slv.slv_o_valid
           & slv.slv_o_rd0_wr1;
    slv_rd = slv.cmd_en & slv.slv_o_valid
           & ~slv.slv_o_rd0_wr1;
    // Bus writes win; the engine retries.
    eng_go  = eng.cmd_rd_en & ~slv_wr;
    addr_hi = eng.cmd_addr + AW'(1);
  end

  always_comb begin
    slv_rd_valid_d = 1'b0;
    slv_rd_data_d  = '0;
    cmd_rd_valid_d = 1'b0;
    cmd_out_d      = '0;
    if (slv_rd) begin
      slv_rd_valid_d = 1'b1;
      slv_rd_data_d  = cmd_mem[slv.trans_addr];
    end
    if (eng_go) begin
      cmd_rd_valid_d = 1'b1;
      cmd_out_d      = {rotr2(cmd_mem[addr_hi]),
                        cmd_mem[eng.cmd_addr]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        cmd_mem[i] <= '0;
      end
    end else if (slv_wr) begin
      cmd_mem[slv.trans_addr] <= slv.slv_o_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_rd_valid_q <= 1'b0;
      slv_rd_data_q  <= '0;
      cmd_rd_valid_q <= 1'b0;
      cmd_out_q      <= '0;
    end else begin
      slv_rd_valid_q <= slv_rd_valid_d;
      slv_rd_data_q  <= slv_rd_data_d;
      cmd_rd_valid_q <= cmd_rd_valid_d;
      cmd_out_q      <= cmd_out_d;
    end
  end

  assign slv.slv_i_ready    = 1'b1;
  assign slv.slv_i_rd_valid = slv_rd_valid_q;
  assign slv.slv_i_rd_data  = slv_rd_data_q;
  assign eng.cmd_rd_valid   = cmd_rd_valid_q;
  assign eng.cmd_out        = cmd_out_q;

endmodule

// File: tb/tb_cmd_buffer.sv
// Directed bench for cmd_buffer: bus and engine
// read/write, arbitration, wrap and async reset.
module tb_cmd_buffer;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  logic [31:0] model [0:255];

  cmd_slv_if sif ();
  cmd_rd_if  rif ();

  cmd_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .slv   (sif),
    .eng   (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sif.cmd_en        = 1'b0;
    sif.slv_o_valid   = 1'b0;
    sif.slv_o_rd0_wr1 = 1'b0;
    sif.trans_addr    = '0;
    sif.slv_o_wr_data = '0;
    rif.cmd_rd_en     = 1'b0;
    rif.cmd_addr      = '0;
  endtask

  task automatic bus(input logic wr,
                     input logic [7:0] a,
                     input logic [31:0] d);
    sif.cmd_en        = 1'b1;
    sif.slv_o_valid   = 1'b1;
    sif.slv_o_rd0_wr1 = wr;
    sif.trans_addr    = a;
    sif.slv_o_wr_data = d;
  endtask

  task automatic eng(input logic [7:0] a);
    rif.cmd_rd_en = 1'b1;
    rif.cmd_addr  = a;
  endtask

  function automatic logic [31:0] ror2(
    input logic [31:0] w
  );
    return {w[1:0], w[31:2]};
  endfunction

  initial begin
    logic       bad;
    logic [7:0] ra;
    logic [31:0] rd;
    passed = 0;
    total  = 0;
    idle();
    rst_n = 1'b0;
    #22;
    rst_n = 1'b1;
    tick();

    bad = 1'b0;
    for (int i = 0; i < 256; i++)
      if (dut.cmd_mem[i] !== 32'h0) bad = 1'b1;
    chk("rst_mem_zero", 64'(bad), 64'd0);
    chk("rst_ready", 64'(sif.slv_i_ready), 64'd1);
    chk("rst_rd_valid", 64'(sif.slv_i_rd_valid), 64'd0);
    chk("rst_cmd_valid", 64'(rif.cmd_rd_valid), 64'd0);
    chk("rst_cmd_out", rif.cmd_out, 64'd0);

    bus(1'b1, 8'h0A, 32'hDEADBEEF);
    tick();
    chk("wr_no_rdvalid", 64'(sif.slv_i_rd_valid), 64'd0);
    bus(1'b0, 8'h0A, 32'h0);
    tick();
    idle();
    chk("rd_valid", 64'(sif.slv_i_rd_valid), 64'd1);
    chk("rd_data", 64'(sif.slv_i_rd_data),
        64'hDEADBEEF);
    chk("rd_cmd_valid", 64'(rif.cmd_rd_valid), 64'd0);

    eng(8'h0A);
    tick();
    idle();
    chk("eng_valid", 64'(rif.cmd_rd_valid), 64'd1);
    chk("eng_out", rif.cmd_out,
        64'h00000000_DEADBEEF);
    chk("idle_rdvalid", 64'(sif.slv_i_rd_valid), 64'd0);
    chk("idle_rddata", 64'(sif.slv_i_rd_data), 64'd0);

    bus(1'b1, 8'h0B, 32'hCAFEBABE);
    eng(8'h0B);
    tick();
    idle();
    chk("arb_mem", 64'(dut.cmd_mem[8'h0B]),
        64'hCAFEBABE);
    chk("arb_valid", 64'(rif.cmd_rd_valid), 64'd0);
    chk("arb_out", rif.cmd_out, 64'd0);

    for (int i = 0; i < 256; i++) begin
      bus(1'b1, 8'(i), 32'(i));
      model[i] = 32'(i);
      tick();
    end
    idle();
    tick();
    chk("idle_cmd_out", rif.cmd_out, 64'd0);

    bus(1'b0, 8'h10, 32'h0);
    eng(8'h10);
    tick();
    idle();
    chk("dual_eng_out", rif.cmd_out,
        64'h40000004_00000010);
    chk("dual_rd_data", 64'(sif.slv_i_rd_data), 64'h10);
    chk("dual_eng_valid", 64'(rif.cmd_rd_valid), 64'd1);
    chk("dual_rd_valid", 64'(sif.slv_i_rd_valid), 64'd1);

    bus(1'b0, 8'h30, 32'h0);
    eng(8'h20);
    tick();
    idle();
    chk("dual2_eng_out", rif.cmd_out,
        64'h40000008_00000020);
    chk("dual2_rd_data", 64'(sif.slv_i_rd_data), 64'h30);
    chk("dual2_valids",
        64'({sif.slv_i_rd_valid, rif.cmd_rd_valid}),
        64'd3);

    bus(1'b1, 8'hFF, 32'hCAFECAFE);
    model[255] = 32'hCAFECAFE;
    tick();
    bus(1'b0, 8'hFF, 32'h0);
    tick();
    idle();
    chk("ff_readback", 64'(sif.slv_i_rd_data),
        64'hCAFECAFE);

    for (int n = 0; n < 10; n++) begin
      ra = 8'($urandom_range(0, 255));
      rd = $urandom;
      bus(1'b1, ra, rd);
      model[ra] = rd;
      tick();
      bus(1'b0, ra, 32'h0);
      tick();
      idle();
      chk($sformatf("rand_rd_%0d", n),
          64'(sif.slv_i_rd_data), 64'(model[ra]));
    end

    eng(8'hFF);
    tick();
    idle();
    chk("wrap_out", rif.cmd_out,
        {ror2(model[0]), model[255]});

    bus(1'b1, 8'h05, 32'h12345678);
    eng(8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_mem_ff", 64'(dut.cmd_mem[8'hFF]), 64'd0);
    chk("async_cmd_valid", 64'(rif.cmd_rd_valid), 64'd0);
    tick();
    chk("async_mem_05", 64'(dut.cmd_mem[8'h05]), 64'd0);
    idle();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
